// File: rtl/accumulator_signed_sat_param.sv
// Signed multiply-accumulate back end: sums NUM_TERMS signed products with per-add
// saturation, then presents the MSB slice of the sum through a valid/ready handshake.
module accumulator_signed_sat_param #(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int ACC_WIDTH      = 16,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int NUM_TERMS      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out,
  output logic                             sat_flag
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_e;

  state_e                            state_q,     state_d;
  logic signed [ACC_WIDTH-1:0]       acc_q,       acc_d;
  logic        [CNT_W-1:0]           cnt_q,       cnt_d;
  logic                              sticky_q,    sticky_d;
  logic                              out_valid_q, out_valid_d;
  logic signed [DATA_OUT_WIDTH-1:0]  data_out_q,  data_out_d;
  logic                              sat_flag_q,  sat_flag_d;

  logic                              accept;
  logic signed [ACC_WIDTH-1:0]       term_ext;
  logic signed [ACC_WIDTH:0]         sum_wide;
  logic                              add_ovf;
  logic signed [ACC_WIDTH-1:0]       sat_sum;

  // in_ready depends only on registered state plus clear/rst, never on in_valid.
  assign in_ready = (state_q == ST_ACC) && !clear && !rst;
  assign accept   = in_valid && in_ready;

  // One guard bit: the two top bits of the wide sum disagree exactly on overflow.
  assign term_ext = ACC_WIDTH'(data_in);
  assign sum_wide = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(term_ext);
  assign add_ovf  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
  assign sat_sum  = add_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                            : sum_wide[ACC_WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path can infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    sat_flag_d  = sat_flag_q;

    unique case (state_q)
      ST_ACC: begin
        if (clear) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (accept) begin
          acc_d = sat_sum;
          if (cnt_q == LAST_CNT) begin
            data_out_d  = sat_sum[ACC_WIDTH-1 -: DATA_OUT_WIDTH];
            sat_flag_d  = sticky_q | add_ovf;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | add_ovf;
          end
        end
      end

      ST_DONE: begin
        // A clear while holding a result is treated as a handoff that drops it.
        if (clear || out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          sticky_d    = 1'b0;
          state_d     = ST_ACC;
        end
      end

      default: state_d = ST_ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only a handful of flops, so every one is reset, outputs included.
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_accumulator_signed_sat_param.sv
// Directed bench: 4-term accumulator (8-bit in, 9-bit acc, 8-bit out) plus a
// single-term instance for the one-bubble throughput case.
module tb_accumulator_signed_sat_param;

  logic              clk = 1'b0;
  logic              rst, clear, in_valid, out_ready;
  logic signed [7:0] data_in;
  logic              in_ready, out_valid, sat_flag;
  logic        [7:0] data_out;

  logic              n1_in_valid, n1_in_ready, n1_out_valid, n1_sat_flag;
  logic signed [7:0] n1_data_in;
  logic        [7:0] n1_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulator_signed_sat_param #(
    .DATA_IN_WIDTH(8), .ACC_WIDTH(9), .DATA_OUT_WIDTH(8), .NUM_TERMS(4)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sat_flag(sat_flag)
  );

  accumulator_signed_sat_param #(
    .DATA_IN_WIDTH(8), .ACC_WIDTH(9), .DATA_OUT_WIDTH(8), .NUM_TERMS(1)
  ) u_dut_n1 (
    .clk(clk), .rst(rst), .clear(1'b0),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready), .data_in(n1_data_in),
    .out_valid(n1_out_valid), .out_ready(1'b1),
    .data_out(n1_data_out), .sat_flag(n1_sat_flag)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [7:0] v);
    in_valid = 1'b1;
    data_in  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] exp_data,
                              input logic exp_sat);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(data_out),  32'(exp_data));
    check({tag, "_sat"},   32'(sat_flag),  32'(exp_sat));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n1_accepts;
    int n1_results;
    logic [7:0] n1_last_data;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_data_in = '0;

    // Reset state.
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out",  32'(data_out),  32'd0);
    check("rst_sat_flag",  32'(sat_flag),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic sum: 10+20-5+7 = 32 -> acc[8:1] = 0x10, one-cycle latency.
    feed(8'sd10); feed(8'sd20); feed(-8'sd5);
    check("basic_no_early_valid", 32'(out_valid), 32'd0);
    feed(8'sd7);
    check_result("basic", 8'h10, 1'b0);
    check("basic_done_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("basic_handoff_valid", 32'(out_valid), 32'd0);
    check("basic_handoff_ready", 32'(in_ready),  32'd1);

    // Positive saturation: 127 x4 clamps at 255.
    repeat (4) feed(8'sd127);
    check_result("pos_sat", 8'h7F, 1'b1);
    tick();

    // Negative saturation: -128 x4 clamps at -256.
    repeat (4) feed(-8'sd128);
    check_result("neg_sat", 8'h80, 1'b1);
    tick();

    // Backpressure: 1+2+3+4 = 10 -> 0x05 held while terms are offered.
    feed(8'sd1); feed(8'sd2); feed(8'sd3);
    out_ready = 1'b0;
    feed(8'sd4);
    check_result("hold_first", 8'h05, 1'b0);
    in_valid = 1'b1; data_in = 8'sd50;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_data",     32'(data_out),  32'h05);
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("hold_release_valid", 32'(out_valid), 32'd0);
    repeat (4) feed(8'sd6);
    check_result("after_hold", 8'h0C, 1'b0);
    tick();

    // Reset mid-accumulation discards the partial sum and the old data_out.
    feed(8'sd50); feed(8'sd50);
    rst = 1'b1;
    tick();
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_data",     32'(data_out),  32'd0);
    check("midrst_sat",      32'(sat_flag),  32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    repeat (4) feed(8'sd1);
    check_result("after_rst", 8'h02, 1'b0);
    tick();

    // Clear after a saturating add drops the offered term and the sticky bit.
    feed(8'sd127); feed(8'sd127); feed(8'sd127);
    clear = 1'b1; in_valid = 1'b1; data_in = 8'sd100;
    #1;
    check("clear_in_ready", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clear_no_valid", 32'(out_valid), 32'd0);
    repeat (4) feed(8'sd2);
    check_result("after_clear", 8'h04, 1'b0);
    tick();

    // Clear while holding a result discards it.
    out_ready = 1'b0;
    repeat (4) feed(8'sd3);
    check_result("done_clear_pre", 8'h06, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b1;
    check("done_clear_valid", 32'(out_valid), 32'd0);
    repeat (4) feed(8'sd2);
    check_result("done_clear_next", 8'h04, 1'b0);
    tick();

    // Gapped input with garbage on data_in while idle.
    foreach (data_in[i]) begin end
    begin
      logic signed [7:0] terms [4];
      terms[0] = 8'sd10; terms[1] = 8'sd20; terms[2] = -8'sd5; terms[3] = 8'sd7;
      for (int k = 0; k < 4; k++) begin
        data_in = 8'sd99;
        repeat ($urandom_range(1, 3)) tick();
        check("gap_no_early_valid", 32'(out_valid), 32'd0);
        feed(terms[k]);
      end
    end
    check_result("gapped", 8'h10, 1'b0);
    tick();

    // NUM_TERMS = 1: 6 -> acc[8:1] = 3, one bubble between acceptances.
    n1_accepts = 0; n1_results = 0; n1_last_data = '0;
    n1_in_valid = 1'b1; n1_data_in = 8'sd6;
    for (int i = 0; i < 8; i++) begin
      if (n1_in_ready) n1_accepts++;
      tick();
      if (n1_out_valid) begin
        n1_results++;
        n1_last_data = n1_data_out;
      end
    end
    n1_in_valid = 1'b0;
    check("n1_accepts", 32'(n1_accepts),   32'd4);
    check("n1_results", 32'(n1_results),   32'd4);
    check("n1_data",    32'(n1_last_data), 32'h03);
    check("n1_sat",     32'(n1_sat_flag),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
